// File: rtl/alu_rr_sched_if.sv
// Request/response bundle between the requester pool (master) and alu_rr_sched (slave).
// Flat per-requester slices: op [2i+1:2i], a/b [16i+15:16i], data [32i+31:32i].
interface alu_rr_sched_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]    req_valid;
    logic [NREQ-1:0]    req_ready;
    logic [2*NREQ-1:0]  req_op;
    logic [16*NREQ-1:0] req_a;
    logic [16*NREQ-1:0] req_b;
    logic [NREQ-1:0]    rsp_valid;
    logic [NREQ-1:0]    rsp_ready;
    logic [32*NREQ-1:0] rsp_data;
    logic [NREQ-1:0]    busy;

    modport master (
        output req_valid, req_op, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, busy
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_data, busy
    );
endinterface

// File: rtl/alu_rr_sched.sv
// Round-robin issue of requester ops onto one shared 2-cycle ALU; ALU_SCHED_HOLD_EN holds idle ALU inputs.
// Latency: grant in cycle T drives the ALU combinationally, rsp_valid rises in T+LAT+1.
// Backpressure: one op in flight per requester; busy blocks re-grant until the response is consumed.
module alu_rr_sched #(
    parameter int NREQ = 4,
    parameter int LAT  = 2
) (
    input  logic          clk,
    input  logic          reset,
    alu_rr_sched_if.slave bus,
    output logic [1:0]    alu_op,
    output logic [15:0]   alu_a,
    output logic [15:0]   alu_b,
    input  logic [31:0]   alu_y
);
    localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int IW1 = IW + 1;

    logic [IW-1:0]      ptr;
    logic [NREQ-1:0]    busy_q;
    logic [NREQ-1:0]    rsp_vld_q;
    logic [32*NREQ-1:0] rsp_dat_q;
    logic [LAT-1:0]     tag_vld;
    logic [IW-1:0]      tag_id [LAT];

    logic [NREQ-1:0] elig;
    logic            gnt_vld;
    logic [IW-1:0]   gnt_id;
    logic [NREQ-1:0] gnt_oh;
    logic [IW1-1:0]  scan;
    logic [1:0]      win_op;
    logic [15:0]     win_a;
    logic [15:0]     win_b;

    // Gating with reset keeps req_ready low while reset is held.
    assign elig = bus.req_valid & ~busy_q & {NREQ{reset}};

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        scan    = '0;
        for (int k = 0; k < NREQ; k++) begin
            scan = {1'b0, ptr} + IW1'(k);
            if (scan >= IW1'(NREQ)) begin
                scan = scan - IW1'(NREQ);
            end
            if (!gnt_vld && elig[scan[IW-1:0]]) begin
                gnt_vld = 1'b1;
                gnt_id  = scan[IW-1:0];
            end
        end
    end

    always_comb begin
        gnt_oh = '0;
        win_op = '0;
        win_a  = '0;
        win_b  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (gnt_vld && gnt_id == IW'(i)) begin
                gnt_oh[i] = 1'b1;
                win_op    = bus.req_op[2*i +: 2];
                win_a     = bus.req_a[16*i +: 16];
                win_b     = bus.req_b[16*i +: 16];
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ptr       <= '0;
            busy_q    <= '0;
            rsp_vld_q <= '0;
            rsp_dat_q <= '0;
            tag_vld   <= '0;
            for (int s = 0; s < LAT; s++) begin
                tag_id[s] <= '0;
            end
        end else begin
            if (gnt_vld) begin
                ptr <= (gnt_id == IW'(NREQ - 1)) ? '0 : gnt_id + IW'(1);
            end
            tag_vld[0] <= gnt_vld;
            tag_id[0]  <= gnt_id;
            for (int s = 1; s < LAT; s++) begin
                tag_vld[s] <= tag_vld[s-1];
                tag_id[s]  <= tag_id[s-1];
            end
            // Capture and consume never target the same requester: busy blocks a second issue.
            for (int i = 0; i < NREQ; i++) begin
                if (rsp_vld_q[i] && bus.rsp_ready[i]) begin
                    rsp_vld_q[i] <= 1'b0;
                    busy_q[i]    <= 1'b0;
                end
                if (gnt_oh[i]) begin
                    busy_q[i] <= 1'b1;
                end
                if (tag_vld[LAT-1] && tag_id[LAT-1] == IW'(i)) begin
                    rsp_vld_q[i]          <= 1'b1;
                    rsp_dat_q[32*i +: 32] <= alu_y;
                end
            end
        end
    end

`ifdef ALU_SCHED_HOLD_EN
    logic [1:0]  hold_op;
    logic [15:0] hold_a;
    logic [15:0] hold_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hold_op <= '0;
            hold_a  <= '0;
            hold_b  <= '0;
        end else if (gnt_vld) begin
            hold_op <= win_op;
            hold_a  <= win_a;
            hold_b  <= win_b;
        end
    end

    // Idle cycles replay the last issue so the ALU inputs do not toggle.
    assign alu_op = gnt_vld ? win_op : hold_op;
    assign alu_a  = gnt_vld ? win_a  : hold_a;
    assign alu_b  = gnt_vld ? win_b  : hold_b;
`else
    assign alu_op = gnt_vld ? win_op : 2'b0;
    assign alu_a  = gnt_vld ? win_a  : 16'h0;
    assign alu_b  = gnt_vld ? win_b  : 16'h0;
`endif

    assign bus.req_ready = gnt_oh;
    assign bus.rsp_valid = rsp_vld_q;
    assign bus.rsp_data  = rsp_dat_q;
    assign bus.busy      = busy_q;
endmodule

// File: tb/tb_alu_rr_sched.sv
// Bench for alu_rr_sched: scenario tasks plus randomized traffic against a queue-based reference model.
// Includes a 2-stage registered ALU so results flow through the real issue/return timing.
module tb_alu_rr_sched;
    localparam int N   = 4;
    localparam int LAT = 2;

`ifdef ALU_SCHED_HOLD_EN
    localparam logic [1:0]  IDLE_OP = 2'd1;
    localparam logic [15:0] IDLE_A  = 16'h1234;
    localparam logic [15:0] IDLE_B  = 16'h00FF;
`else
    localparam logic [1:0]  IDLE_OP = 2'd0;
    localparam logic [15:0] IDLE_A  = 16'h0000;
    localparam logic [15:0] IDLE_B  = 16'h0000;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    alu_rr_sched_if #(.NREQ(N)) bus ();
    logic [1:0]  alu_op;
    logic [15:0] alu_a;
    logic [15:0] alu_b;
    logic [31:0] alu_y;

    alu_rr_sched #(.NREQ(N), .LAT(LAT)) dut (
        .clk    (clk),
        .reset  (reset),
        .bus    (bus),
        .alu_op (alu_op),
        .alu_a  (alu_a),
        .alu_b  (alu_b),
        .alu_y  (alu_y)
    );

    function automatic logic [31:0] alu_fn(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        case (op)
            2'd0:    return 32'(a) * 32'(b);
            2'd1:    return 32'(a) + 32'(b);
            2'd2:    return {16'h0, a & b};
            default: return {16'h0, a | b};
        endcase
    endfunction

    // Environment ALU: input register then output register.
    logic [1:0]  x_op;
    logic [15:0] x_a;
    logic [15:0] x_b;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_op  <= '0;
            x_a   <= '0;
            x_b   <= '0;
            alu_y <= '0;
        end else begin
            x_op  <= alu_op;
            x_a   <= alu_a;
            x_b   <= alu_b;
            alu_y <= alu_fn(x_op, x_a, x_b);
        end
    end

    // Reference model state
    typedef struct {
        int          id;
        logic [31:0] res;
        int          due;
    } pend_t;

    int          m_ptr;
    bit          m_busy [N];
    bit          m_vld  [N];
    logic [31:0] m_dat  [N];
    pend_t       pend   [$];
    int          cyc;
`ifdef ALU_SCHED_HOLD_EN
    logic [1:0]  m_hop;
    logic [15:0] m_ha;
    logic [15:0] m_hb;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    logic [N-1:0]   obs_rdy, obs_vld, obs_busy, exp_rdy, exp_vld, exp_busy;
    logic [32*N-1:0] obs_dat, exp_dat;
    logic [1:0]     obs_op, exp_op;
    logic [15:0]    obs_a, obs_b, exp_a, exp_b;

    task automatic model_clear();
        m_ptr = 0;
        for (int i = 0; i < N; i++) begin
            m_busy[i] = 1'b0;
            m_vld[i]  = 1'b0;
            m_dat[i]  = '0;
        end
        pend.delete();
`ifdef ALU_SCHED_HOLD_EN
        m_hop = '0;
        m_ha  = '0;
        m_hb  = '0;
`endif
    endtask

    function automatic int pick();
        for (int k = 0; k < N; k++) begin
            int i;
            i = (m_ptr + k) % N;
            if (bus.req_valid[i] && !m_busy[i]) return i;
        end
        return -1;
    endfunction

    // One clock: snapshot DUT and model at negedge, advance the model at posedge.
    task automatic advance();
        int          g;
        logic [1:0]  op;
        logic [15:0] a, b;
        pend_t       p;
        @(negedge clk);
        g = pick();
        exp_rdy = '0;
        op = '0;
        a  = '0;
        b  = '0;
        if (g >= 0) begin
            exp_rdy[g] = 1'b1;
            op = bus.req_op[2*g +: 2];
            a  = bus.req_a[16*g +: 16];
            b  = bus.req_b[16*g +: 16];
        end
        exp_op = op;
        exp_a  = a;
        exp_b  = b;
`ifdef ALU_SCHED_HOLD_EN
        if (g < 0) begin
            exp_op = m_hop;
            exp_a  = m_ha;
            exp_b  = m_hb;
        end
`endif
        for (int i = 0; i < N; i++) begin
            exp_vld[i]           = m_vld[i];
            exp_busy[i]          = m_busy[i];
            exp_dat[32*i +: 32]  = m_dat[i];
        end
        obs_rdy  = bus.req_ready;
        obs_vld  = bus.rsp_valid;
        obs_busy = bus.busy;
        obs_dat  = bus.rsp_data;
        obs_op   = alu_op;
        obs_a    = alu_a;
        obs_b    = alu_b;
        @(posedge clk);
        for (int i = 0; i < N; i++) begin
            if (m_vld[i] && bus.rsp_ready[i]) begin
                m_vld[i]  = 1'b0;
                m_busy[i] = 1'b0;
            end
        end
        for (int q = pend.size() - 1; q >= 0; q--) begin
            if (pend[q].due == cyc + 1) begin
                m_vld[pend[q].id] = 1'b1;
                m_dat[pend[q].id] = pend[q].res;
                pend.delete(q);
            end
        end
        if (g >= 0) begin
            m_busy[g] = 1'b1;
            m_ptr     = (g + 1) % N;
            p.id  = g;
            p.res = alu_fn(op, a, b);
            p.due = cyc + LAT + 1;
            pend.push_back(p);
`ifdef ALU_SCHED_HOLD_EN
            m_hop = op;
            m_ha  = a;
            m_hb  = b;
`endif
        end
        cyc++;
        #1;
    endtask

    task automatic set_req(input int i, input logic v, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        bus.req_valid[i]       = v;
        bus.req_op[2*i +: 2]   = op;
        bus.req_a[16*i +: 16]  = a;
        bus.req_b[16*i +: 16]  = b;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;
        bus.req_valid = '0;
        bus.rsp_ready = '0;
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'd1, 16'(i + 7), 16'h0101);
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.req_ready !== '0) begin n_bad++; $display("FAIL reset_req_ready: got %b want 0", bus.req_ready); end
        n_cmp++; if (bus.rsp_valid !== '0) begin n_bad++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_cmp++; if (bus.rsp_data !== '0) begin n_bad++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
        n_cmp++; if (bus.busy !== '0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
        n_cmp++; if ({alu_op, alu_a, alu_b} !== '0) begin n_bad++; $display("FAIL reset_alu_in: got %h/%h/%h want 0", alu_op, alu_a, alu_b); end
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        bus.req_valid = '0;
        reset = 1'b1;
    endtask

    task automatic test_single();
        set_req(0, 1'b1, 2'd0, 16'd3, 16'd5);
        advance();
        n_cmp++; if (obs_rdy !== 4'b0001) begin n_bad++; $display("FAIL single_grant: got %b want 0001", obs_rdy); end
        n_cmp++; if (obs_a !== 16'd3 || obs_b !== 16'd5) begin n_bad++; $display("FAIL single_issue: got %h/%h want 3/5", obs_a, obs_b); end
        bus.req_valid[0] = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            advance();
            n_cmp++; if (obs_vld[0] !== 1'b0 || obs_busy[0] !== 1'b1) begin n_bad++; $display("FAIL single_wait c%0d: vld %b busy %b want 0/1", c, obs_vld[0], obs_busy[0]); end
        end
        advance();
        n_cmp++; if (obs_vld !== 4'b0001) begin n_bad++; $display("FAIL single_rsp_valid: got %b want 0001", obs_vld); end
        n_cmp++; if (obs_dat[31:0] !== 32'd15) begin n_bad++; $display("FAIL single_rsp_data: got %0d want 15", obs_dat[31:0]); end
        bus.rsp_ready[0] = 1'b1;
        advance();
        bus.rsp_ready[0] = 1'b0;
        advance();
        n_cmp++; if (obs_busy !== 4'b0000 || obs_vld !== 4'b0000) begin n_bad++; $display("FAIL single_clear: busy %b vld %b want 0/0", obs_busy, obs_vld); end
    endtask

    task automatic test_all_four();
        logic [N-1:0] e;
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 1'b1, 2'd0, 16'(i + 1), 16'd10);
        for (int c = 0; c <= 6; c++) begin
            advance();
            e = '0;
            if (c < N) e[c] = 1'b1;
            n_cmp++; if (obs_rdy !== e) begin n_bad++; $display("FAIL four_grant c%0d: got %b want %b", c, obs_rdy, e); end
            e = '0;
            for (int k = 0; k <= c - 3; k++) e[k] = 1'b1;
            n_cmp++; if (obs_vld !== e) begin n_bad++; $display("FAIL four_rsp_valid c%0d: got %b want %b", c, obs_vld, e); end
            if (c >= 3) begin
                n_cmp++; if (obs_dat[32*(c-3) +: 32] !== 32'((c - 2) * 10)) begin n_bad++; $display("FAIL four_rsp_data c%0d: got %0d want %0d", c, obs_dat[32*(c-3) +: 32], (c - 2) * 10); end
            end
            if (c < N) bus.req_valid[c] = 1'b0;
        end
        bus.rsp_ready = '1;
        advance();
        bus.rsp_ready = '0;
    endtask

    task automatic test_fairness();
        do_reset();
        bus.rsp_ready = '1;
        set_req(1, 1'b1, 2'd1, 16'd7, 16'd8);
        advance();
        n_cmp++; if (obs_rdy !== 4'b0010) begin n_bad++; $display("FAIL fair_first: got %b want 0010", obs_rdy); end
        bus.req_valid[1] = 1'b0;
        set_req(0, 1'b1, 2'd2, 16'hF0F0, 16'h0FF0);
        set_req(3, 1'b1, 2'd3, 16'h0001, 16'h0100);
        advance();
        n_cmp++; if (obs_rdy !== 4'b1000) begin n_bad++; $display("FAIL fair_wrap3: got %b want 1000", obs_rdy); end
        bus.req_valid[3] = 1'b0;
        advance();
        n_cmp++; if (obs_rdy !== 4'b0001) begin n_bad++; $display("FAIL fair_then0: got %b want 0001", obs_rdy); end
        bus.req_valid[0] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            advance();
            n_cmp++; if (obs_vld !== exp_vld || obs_dat !== exp_dat) begin n_bad++; $display("FAIL fair_drain c%0d: vld %b want %b data %h want %h", c, obs_vld, exp_vld, obs_dat, exp_dat); end
        end
    endtask

    task automatic test_backpressure();
        int others;
        others = 0;
        do_reset();
        bus.rsp_ready = 4'b1101;
        set_req(1, 1'b1, 2'd0, 16'hFFFF, 16'hFFFF);
        advance();
        n_cmp++; if (obs_rdy !== 4'b0010) begin n_bad++; $display("FAIL bp_first: got %b want 0010", obs_rdy); end
        set_req(1, 1'b1, 2'd1, 16'd1, 16'd1);
        set_req(0, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
        set_req(2, 1'b1, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
        for (int c = 1; c <= 13; c++) begin
            advance();
            n_cmp++; if (obs_rdy !== exp_rdy) begin n_bad++; $display("FAIL bp_grant c%0d: got %b want %b", c, obs_rdy, exp_rdy); end
            n_cmp++; if (obs_rdy[1] !== 1'b0) begin n_bad++; $display("FAIL bp_regrant c%0d: got %b want 0", c, obs_rdy[1]); end
            if (obs_rdy[0] || obs_rdy[2]) others++;
            if (c >= 3) begin
                n_cmp++; if (obs_vld[1] !== 1'b1 || obs_dat[63:32] !== 32'hFFFE0001) begin n_bad++; $display("FAIL bp_hold c%0d: vld %b data %h want 1/fffe0001", c, obs_vld[1], obs_dat[63:32]); end
            end
        end
        n_cmp++; if (others < 4) begin n_bad++; $display("FAIL bp_others: got %0d grants want >=4", others); end
        bus.rsp_ready[1] = 1'b1;
        advance();
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        for (int c = 0; c < 6; c++) begin
            advance();
            n_cmp++; if (obs_vld !== exp_vld || obs_busy !== exp_busy) begin n_bad++; $display("FAIL bp_drain c%0d: vld %b want %b busy %b want %b", c, obs_vld, exp_vld, obs_busy, exp_busy); end
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        bus.rsp_ready = 4'b0001;
        set_req(0, 1'b1, 2'd1, 16'd100, 16'd23);
        for (int c = 0; c < 12; c++) begin
            advance();
            n_cmp++; if (obs_rdy[0] !== ((c % (LAT + 2)) == 0)) begin n_bad++; $display("FAIL b2b_grant c%0d: got %b want %b", c, obs_rdy[0], (c % (LAT + 2)) == 0); end
            n_cmp++; if (obs_dat !== exp_dat) begin n_bad++; $display("FAIL b2b_data c%0d: got %h want %h", c, obs_dat, exp_dat); end
        end
        bus.req_valid = '0;
        repeat (4) advance();
    endtask

    task automatic test_reset_mid();
        do_reset();
        set_req(2, 1'b1, 2'd0, 16'd9, 16'd9);
        advance();
        n_cmp++; if (obs_rdy !== 4'b0100) begin n_bad++; $display("FAIL mid_grant: got %b want 0100", obs_rdy); end
        bus.req_valid[2] = 1'b0;
        advance();
        reset = 1'b0;
        #1;
        n_cmp++; if (bus.busy !== '0 || bus.rsp_valid !== '0 || bus.req_ready !== '0) begin n_bad++; $display("FAIL mid_reset_ctl: busy %b vld %b rdy %b want 0", bus.busy, bus.rsp_valid, bus.req_ready); end
        n_cmp++; if (bus.rsp_data !== '0 || {alu_op, alu_a, alu_b} !== '0) begin n_bad++; $display("FAIL mid_reset_dat: data %h alu %h/%h/%h want 0", bus.rsp_data, alu_op, alu_a, alu_b); end
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int c = 0; c < 6; c++) begin
            advance();
            n_cmp++; if (obs_vld !== 4'b0000 || obs_busy !== 4'b0000) begin n_bad++; $display("FAIL mid_after c%0d: vld %b busy %b want 0/0", c, obs_vld, obs_busy); end
        end
    endtask

    task automatic test_hold();
        do_reset();
        bus.rsp_ready = '1;
        set_req(3, 1'b1, 2'd1, 16'h1234, 16'h00FF);
        advance();
        n_cmp++; if (obs_a !== 16'h1234 || obs_b !== 16'h00FF || obs_op !== 2'd1) begin n_bad++; $display("FAIL hold_issue: got %h/%h/%h want 1/1234/00ff", obs_op, obs_a, obs_b); end
        bus.req_valid[3] = 1'b0;
        for (int c = 0; c < 5; c++) begin
            advance();
            n_cmp++; if (obs_a !== IDLE_A || obs_b !== IDLE_B || obs_op !== IDLE_OP) begin n_bad++; $display("FAIL hold_idle c%0d: got %h/%h/%h want %h/%h/%h", c, obs_op, obs_a, obs_b, IDLE_OP, IDLE_A, IDLE_B); end
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                set_req(i, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom));
                bus.rsp_ready[i] = ($urandom_range(0, 1) == 1);
            end
            advance();
            n_cmp++; if (obs_rdy !== exp_rdy) begin n_bad++; $display("FAIL rnd_ready c%0d: got %b want %b", c, obs_rdy, exp_rdy); end
            n_cmp++; if (obs_vld !== exp_vld) begin n_bad++; $display("FAIL rnd_rsp_valid c%0d: got %b want %b", c, obs_vld, exp_vld); end
            n_cmp++; if (obs_busy !== exp_busy) begin n_bad++; $display("FAIL rnd_busy c%0d: got %b want %b", c, obs_busy, exp_busy); end
            n_cmp++; if (obs_dat !== exp_dat) begin n_bad++; $display("FAIL rnd_rsp_data c%0d: got %h want %h", c, obs_dat, exp_dat); end
            n_cmp++; if (obs_op !== exp_op) begin n_bad++; $display("FAIL rnd_alu_op c%0d: got %h want %h", c, obs_op, exp_op); end
            n_cmp++; if (obs_a !== exp_a) begin n_bad++; $display("FAIL rnd_alu_a c%0d: got %h want %h", c, obs_a, exp_a); end
            n_cmp++; if (obs_b !== exp_b) begin n_bad++; $display("FAIL rnd_alu_b c%0d: got %h want %h", c, obs_b, exp_b); end
        end
        bus.req_valid = '0;
        bus.rsp_ready = '1;
        repeat (5) advance();
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = '0;
        bus.req_op    = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = '0;
        cyc = 0;
        model_clear();
        #2;
        test_reset();
        test_single();
        test_all_four();
        test_fairness();
        test_backpressure();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
